// File: rtl/i2s_mic_if.sv
// Bus bundle for the I2S microphone emulator: control, sample-buffer write port
// and the serial/status outputs.
interface i2s_mic_if #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 256
);
    localparam int ADDR_W = $clog2(MEM_DEPTH);

    logic                  enable;
    logic                  stereo;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  i2s_ws;
    logic                  i2s_data;
    logic                  frame_start;
    logic [ADDR_W-1:0]     rd_addr;

    modport master (
        output enable, stereo, wr_en, wr_addr, wr_data,
        input  i2s_ws, i2s_data, frame_start, rd_addr
    );

    modport slave (
        input  enable, stereo, wr_en, wr_addr, wr_data,
        output i2s_ws, i2s_data, frame_start, rd_addr
    );
endinterface

// File: rtl/i2s_mic_emu.sv
// I2S microphone emulator: streams samples from a writable buffer as
// MSB-first I2S frames with the standard one-bit data delay.
//
// state | meaning
// IDLE  | outputs quiet, rd_addr retained, waiting for enable
// RUN   | streaming left/right slots, stops only at a frame boundary
module i2s_mic_emu #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic      i2s_clk,
    input  logic      reset,
    i2s_mic_if.slave  bus
);
    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int CNT_W  = $clog2(SLOT_WIDTH);

    if (DATA_WIDTH < 2 || DATA_WIDTH > SLOT_WIDTH - 1 || SLOT_WIDTH < 4 ||
        SLOT_WIDTH > 64 || MEM_DEPTH < 2 || (MEM_DEPTH % 2) != 0) begin : g_param_check
        $error("i2s_mic_emu: illegal parameter combination");
    end

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    typedef logic [DATA_WIDTH-1:0] mem_t [MEM_DEPTH];

    function automatic mem_t ramp_init();
        mem_t r;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            r[i] = DATA_WIDTH'(i);
        end
        return r;
    endfunction

    // Modulo-MEM_DEPTH add; MEM_DEPTH need not be a power of two.
    function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a,
                                                   input logic [1:0]        step);
        logic [ADDR_W:0] sum;
        sum = {1'b0, a} + (ADDR_W+1)'(step);
        if (sum >= (ADDR_W+1)'(MEM_DEPTH)) begin
            sum = sum - (ADDR_W+1)'(MEM_DEPTH);
        end
        return sum[ADDR_W-1:0];
    endfunction

    mem_t                  mem = ramp_init();
    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      n;
    logic                  chan;
    logic                  stereo_q;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] shreg;

    logic                  slot_first;
    logic                  slot_last;
    logic                  frame_last;
    logic [DATA_WIDTH-1:0] left_word;
    logic [DATA_WIDTH-1:0] right_word;
    logic [ADDR_W-1:0]     rd_addr_adv;

    logic                  ws_o;
    logic                  data_o;
    logic                  fs_o;

    assign slot_first = (n == '0);
    assign slot_last  = (n == CNT_W'(SLOT_WIDTH - 1));
    assign frame_last = (state == RUN) && chan && slot_last;

    // Asynchronous read sampled at the edge gives read-before-write for free.
    assign left_word   = mem[rd_addr];
    assign right_word  = stereo_q ? mem[addr_add(rd_addr, 2'd1)] : '0;
    assign rd_addr_adv = addr_add(rd_addr, stereo_q ? 2'd2 : 2'd1);

    // Buffer writes are independent of reset and FSM state.
    always_ff @(posedge i2s_clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge i2s_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.enable) state_nxt = RUN;
            RUN:  if (frame_last && !bus.enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i2s_clk) begin
        if (reset) begin
            n        <= '0;
            chan     <= 1'b0;
            stereo_q <= 1'b0;
            rd_addr  <= '0;
            shreg    <= '0;
        end else if (state == RUN) begin
            if (slot_last) begin
                n    <= '0;
                chan <= ~chan;
            end else begin
                n <= n + CNT_W'(1);
            end
            if (slot_first && !chan) begin
                stereo_q <= bus.stereo;
            end
            if (slot_first) begin
                shreg <= chan ? right_word : left_word;
            end else begin
                shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
            end
            if (frame_last) begin
                rd_addr <= rd_addr_adv;
            end
        end else begin
            n    <= '0;
            chan <= 1'b0;
        end
    end

    always_comb begin
        ws_o   = 1'b0;
        data_o = 1'b0;
        fs_o   = 1'b0;
        if (state == RUN) begin
            ws_o = slot_last ? ~chan : chan;
            fs_o = slot_first && !chan;
            if (!slot_first && n <= CNT_W'(DATA_WIDTH)) begin
                data_o = shreg[DATA_WIDTH-1];
            end
        end
    end

    assign bus.i2s_ws      = ws_o;
    assign bus.i2s_data    = data_o;
    assign bus.frame_start = fs_o;
    assign bus.rd_addr     = rd_addr;
endmodule

// File: tb/tb_i2s_mic_emu.sv
// Directed testbench for i2s_mic_emu with hand-computed frame contents.
module tb_i2s_mic_emu;
    localparam int DW = 16;
    localparam int SW = 32;
    localparam int MD = 8;

    logic i2s_clk = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    i2s_mic_if #(.DATA_WIDTH(DW), .MEM_DEPTH(MD)) bus ();

    i2s_mic_emu #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .MEM_DEPTH(MD)) dut (
        .i2s_clk (i2s_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 i2s_clk = ~i2s_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge i2s_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [2:0] exp_addr);
        check({tag, "_ws"},      32'(bus.i2s_ws),      32'h0);
        check({tag, "_data"},    32'(bus.i2s_data),    32'h0);
        check({tag, "_fs"},      32'(bus.frame_start), 32'h0);
        check({tag, "_rd_addr"}, 32'(bus.rd_addr),     32'(exp_addr));
    endtask

    // Called at left-slot n=0; returns at the following frame's n=0 (or IDLE).
    task automatic frame(input logic [15:0] exp_l, input logic [15:0] exp_r,
                         input int drop_at, input string tag);
        logic [15:0] l;
        logic [15:0] r;
        int          bad;
        l   = '0;
        r   = '0;
        bad = 0;
        for (int p = 0; p < 2 * SW; p++) begin
            int   n;
            logic ch;
            n  = p % SW;
            ch = (p >= SW);
            if (bus.frame_start !== (p == 0)) bad++;
            if (bus.i2s_ws !== ((n == SW - 1) ? ~ch : ch)) bad++;
            if (n >= 1 && n <= DW) begin
                if (!ch) l = {l[14:0], bus.i2s_data};
                else     r = {r[14:0], bus.i2s_data};
            end else if (bus.i2s_data !== 1'b0) begin
                bad++;
            end
            if (p == drop_at) bus.enable = 1'b0;
            tick();
            if (p == 0) bus.wr_en = 1'b0;
        end
        check({tag, "_left"},   32'(l),   32'(exp_l));
        check({tag, "_right"},  32'(r),   32'(exp_r));
        check({tag, "_timing"}, 32'(bad), 32'h0);
    endtask

    initial begin
        bus.enable  = 1'b0;
        bus.stereo  = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        reset       = 1'b1;
        tick();
        tick();
        check_idle("reset", 3'd0);

        // Stereo ramp, then run until rd_addr=6 and stop mid right slot.
        reset      = 1'b0;
        bus.stereo = 1'b1;
        bus.enable = 1'b1;
        tick();
        frame(16'h0000, 16'h0001, -1, "st0");
        check("st0_rd_addr", 32'(bus.rd_addr), 32'd2);
        frame(16'h0002, 16'h0003, -1, "st1");
        check("st1_rd_addr", 32'(bus.rd_addr), 32'd4);
        frame(16'h0004, 16'h0005, -1, "st2");
        check("st2_rd_addr", 32'(bus.rd_addr), 32'd6);
        frame(16'h0006, 16'h0007, SW + 10, "stop");
        check_idle("stop_idle", 3'd0);
        tick();
        tick();
        check_idle("stop_hold", 3'd0);

        // Mono single frame from retained rd_addr=0 after overwriting mem[0].
        bus.stereo  = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_data = 16'hA5C3;
        tick();
        bus.wr_en  = 1'b0;
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        frame(16'hA5C3, 16'h0000, -1, "mono");
        check_idle("mono_idle", 3'd1);

        // Reset returns rd_addr to 0 without touching the buffer.
        reset = 1'b1;
        tick();
        check_idle("rst2", 3'd0);
        reset      = 1'b0;
        bus.stereo = 1'b1;
        bus.enable = 1'b1;
        tick();
        // Write lands on the fetch cycle of mem[0]: old data goes out first.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_data = 16'h1234;
        frame(16'hA5C3, 16'h0001, -1, "col0");
        frame(16'h0002, 16'h0003, -1, "col1");
        frame(16'h0004, 16'h0005, -1, "col2");
        frame(16'h0006, 16'h0007, -1, "col3");
        frame(16'h1234, 16'h0001, -1, "col4");
        check("col4_rd_addr", 32'(bus.rd_addr), 32'd2);

        // Mid-frame reset at left n=5, with a write presented during reset.
        for (int i = 0; i < 5; i++) tick();
        reset       = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd3;
        bus.wr_data = 16'hBEEF;
        tick();
        check_idle("rst_mid", 3'd0);
        reset     = 1'b0;
        bus.wr_en = 1'b0;
        tick();
        frame(16'h1234, 16'h0001, -1, "post0");
        frame(16'h0002, 16'hBEEF, -1, "post1");
        frame(16'h0004, 16'h0005, 0, "post2");
        check_idle("end_idle", 3'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
